// File: rtl/crack_ctrl.sv
// rtl/crack_ctrl.sv - ARC4 key-search controller with early reject and N-way key split
module crack_ctrl #(
    parameter int         KEY_W   = 24,
    parameter int         STRIDE  = 1,
    parameter int         OFFSET  = 0,
    parameter logic [7:0] CHAR_LO = 8'h20,
    parameter logic [7:0] CHAR_HI = 8'h7E
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic             kill,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             found,
    output logic [7:0]       str_len,
    output logic [KEY_W-1:0] keys_tried,
    output logic [KEY_W-1:0] a4_key,
    output logic             a4_en,
    output logic             a4_abort,
    input  logic             a4_rdy,
    input  logic [7:0]       pt_addr,
    input  logic [7:0]       pt_wrdata,
    input  logic             pt_wren
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_FOUND,
        S_EXHAUST
    } state_t;

    localparam logic [KEY_W-1:0] KEY_FIRST = KEY_W'(OFFSET);
    localparam logic [KEY_W-1:0] KEY_STEP  = KEY_W'(STRIDE);
    // Largest key that can still be advanced by STRIDE without wrapping
    localparam logic [KEY_W-1:0] KEY_LIMIT = {KEY_W{1'b1}} - KEY_STEP;

    state_t state;
    logic   a4_rdy_q;

    logic printable;
    logic wr_len;
    logic wr_body;
    logic in_run;
    logic hit_found;
    logic hit_reject;
    logic core_done;

    // Classify the snooped plaintext write against the current length byte
    always_comb begin
        printable  = (pt_wrdata >= CHAR_LO) && (pt_wrdata <= CHAR_HI);
        in_run     = (state == S_RUN);
        wr_len     = pt_wren && (pt_addr == 8'd0);
        wr_body    = pt_wren && (pt_addr != 8'd0) && (pt_addr <= str_len);
        hit_found  = in_run && ((wr_len && (pt_wrdata == 8'd0)) ||
                                (wr_body && printable && (pt_addr == str_len)));
        hit_reject = in_run && wr_body && !printable;
        core_done  = in_run && a4_rdy && !a4_rdy_q;
    end

    assign rdy      = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUST);
    assign a4_key   = key;
    assign a4_en    = (state == S_LAUNCH) && a4_rdy && !kill;
    // A found decision suppresses the abort even when kill or a reject coincides
    assign a4_abort = in_run && !hit_found && (kill || hit_reject);

    // Search sequencing: launch core, judge plaintext, step key or finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            key        <= KEY_FIRST;
            key_valid  <= 1'b0;
            found      <= 1'b0;
            str_len    <= 8'd0;
            keys_tried <= '0;
            a4_rdy_q   <= 1'b1;
        end else begin
            found    <= 1'b0;
            a4_rdy_q <= a4_rdy;
            case (state)
                S_IDLE, S_FOUND, S_EXHAUST: begin
                    if (en) begin
                        key        <= KEY_FIRST;
                        keys_tried <= '0;
                        key_valid  <= 1'b0;
                        str_len    <= 8'd0;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (kill) begin
                        key_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (a4_rdy) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wr_len) begin
                        str_len <= pt_wrdata;
                    end
                    if (hit_found) begin
                        key_valid <= 1'b1;
                        found     <= 1'b1;
                        state     <= S_FOUND;
                    end else if (kill) begin
                        key_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (hit_reject || core_done) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (kill) begin
                        key_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        keys_tried <= keys_tried + KEY_W'(1);
                        if (key > KEY_LIMIT) begin
                            state <= S_EXHAUST;
                        end else begin
                            key   <= key + KEY_STEP;
                            state <= S_LAUNCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_ctrl.sv
// tb/tb_crack_ctrl.sv - randomized model-checked bench for crack_ctrl
module tb_crack_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, kill, a4_rdy, pt_wren;
    logic [7:0]  pt_addr, pt_wrdata;
    logic        rdy, key_valid, found, a4_en, a4_abort;
    logic [23:0] key, keys_tried, a4_key;
    logic [7:0]  str_len;

    logic        en2, kill2, a4_rdy2, pt_wren2;
    logic [7:0]  pt_addr2, pt_wrdata2;
    logic        rdy2, key_valid2, found2, a4_en2, a4_abort2;
    logic [3:0]  key2, keys_tried2, a4_key2;
    logic [7:0]  str_len2;

    crack_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .kill(kill), .key(key),
        .key_valid(key_valid), .found(found), .str_len(str_len), .keys_tried(keys_tried),
        .a4_key(a4_key), .a4_en(a4_en), .a4_abort(a4_abort), .a4_rdy(a4_rdy),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    crack_ctrl #(.KEY_W(4), .STRIDE(2), .OFFSET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .kill(kill2), .key(key2),
        .key_valid(key_valid2), .found(found2), .str_len(str_len2), .keys_tried(keys_tried2),
        .a4_key(a4_key2), .a4_en(a4_en2), .a4_abort(a4_abort2), .a4_rdy(a4_rdy2),
        .pt_addr(pt_addr2), .pt_wrdata(pt_wrdata2), .pt_wren(pt_wren2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (search rules over the key sequence) ----------------
    localparam int P_IDLE = 0, P_WAIT = 1, P_RUN = 2, P_STEP = 3, P_FOUND = 4, P_EXH = 5;
    int          m_phase;
    logic [31:0] m_key, m_tried;
    logic [7:0]  m_len;
    logic        m_kv, m_found, m_prev_rdy;
    logic        d_accept, d_reject, d_done;

    task automatic model_reset();
        m_phase = P_IDLE; m_key = 0; m_tried = 0; m_len = 0;
        m_kv = 0; m_found = 0; m_prev_rdy = 1;
    endtask

    // ---------------- core model (dut1) ----------------
    int          c_mode, abort_delay, c_cnt;
    logic [31:0] c_seed, c_key;
    logic [7:0]  c_len, c_cap, c_idx;
    logic        c_busy, c_abrt, en_seen, abort_seen;
    logic [31:0] en_key_cap;
    // core model (dut2): every key rejected at address 1
    logic        c2_busy, c2_rel, en2_seen, ab2_seen;
    logic [7:0]  c2_idx;
    logic [31:0] q2[$];

    function automatic logic [31:0] mix(input logic [31:0] x0);
        logic [31:0] x;
        x = x0 ^ (x0 >> 16);
        x = x * 32'h7feb352d;
        x = x ^ (x >> 15);
        x = x * 32'h846ca68b;
        return x ^ (x >> 16);
    endfunction

    function automatic logic [7:0] f_len(input int md, input logic [31:0] k, input logic [31:0] sd);
        logic [31:0] h;
        h = mix(k ^ sd);
        case (md)
            0: return (k == 3) ? 8'd3 : 8'd5;
            1: return (k == 0) ? 8'd0 : 8'd5;
            2: return (h % 29 == 0) ? 8'd0 : 8'(1 + ((h >> 8) % 4));
            default: return 8'd5;
        endcase
    endfunction

    function automatic logic [7:0] f_cap(input int md, input logic [31:0] k, input logic [31:0] sd);
        logic [31:0] h;
        logic [7:0]  l;
        h = mix(k ^ sd);
        l = f_len(md, k, sd);
        if (md == 2 && l != 0 && ((h >> 12) % 4 == 0)) return l - 8'd1;
        return l;
    endfunction

    function automatic logic [7:0] f_byte(input int md, input logic [31:0] k, input logic [7:0] a,
                                          input logic [31:0] sd);
        logic [31:0] v;
        if (md == 0 && k == 3) begin
            case (a)
                8'd1: return 8'h61;
                8'd2: return 8'h62;
                default: return 8'h63;
            endcase
        end
        if (md == 2) begin
            v = mix(mix(k ^ sd) + 32'(a) * 7919) % 16;
            case (v)
                0: return 8'h1F;
                1: return 8'h7F;
                2: return 8'h20;
                3: return 8'h7E;
                4: return 8'h80;
                default: return 8'h41 + 8'(v);
            endcase
        end
        return (a == 8'd1) ? 8'h07 : 8'h78;
    endfunction

    task automatic core_reset();
        c_busy = 0; c_abrt = 0; c_cnt = 0; c_idx = 0; c_key = 0; c_len = 0; c_cap = 0;
        en_seen = 0; abort_seen = 0;
        c2_busy = 0; c2_rel = 0; c2_idx = 0; en2_seen = 0; ab2_seen = 0;
        a4_rdy = 1; a4_rdy2 = 1;
        pt_wren = 0; pt_addr = 0; pt_wrdata = 0;
        pt_wren2 = 0; pt_addr2 = 0; pt_wrdata2 = 0;
    endtask

    task automatic core_drive();
        pt_wren = 0; pt_addr = 8'($urandom); pt_wrdata = 8'($urandom);
        if (abort_seen) begin
            c_abrt = 1;
            c_cnt  = (abort_delay < 0) ? int'($urandom_range(0, 3)) : abort_delay;
        end
        if (c_abrt) begin
            if (c_cnt == 0) begin c_busy = 0; c_abrt = 0; end
            else c_cnt--;
        end else if (en_seen) begin
            c_busy = 1; c_key = en_key_cap; c_idx = 0;
            c_len = f_len(c_mode, c_key, c_seed); c_cap = f_cap(c_mode, c_key, c_seed);
        end else if (c_busy) begin
            if (c_idx > c_cap) begin
                c_busy = 0;
            end else if (c_mode == 2 && $urandom_range(0, 3) == 0) begin
                if (c_idx != 0 && $urandom_range(0, 3) == 0) begin
                    pt_wren = 1; pt_addr = c_len + 8'd1 + 8'($urandom_range(0, 3)); pt_wrdata = 8'h01;
                end
            end else begin
                pt_wren = 1; pt_addr = c_idx;
                pt_wrdata = (c_idx == 0) ? c_len : f_byte(c_mode, c_key, c_idx, c_seed);
                c_idx++;
            end
        end
        a4_rdy = !c_busy;
        // second core
        pt_wren2 = 0; pt_addr2 = 8'($urandom); pt_wrdata2 = 8'($urandom);
        if (c2_rel) begin c2_busy = 0; c2_rel = 0; end
        if (ab2_seen) c2_rel = 1;
        else if (en2_seen) begin c2_busy = 1; c2_idx = 0; end
        else if (c2_busy && !c2_rel && c2_idx < 2) begin
            pt_wren2 = 1; pt_addr2 = c2_idx; pt_wrdata2 = (c2_idx == 0) ? 8'd2 : 8'h19;
            c2_idx++;
        end
        a4_rdy2 = !c2_busy;
    endtask

    // Compare every output against the model, then advance the model by one clock
    task automatic check_and_step();
        logic printable, body, in_run, exp_en, exp_abort, exp_rdy;
        if (!rst_n) model_reset();
        printable = (pt_wrdata >= 8'h20) && (pt_wrdata <= 8'h7E);
        in_run    = (m_phase == P_RUN);
        body      = pt_wren && pt_addr != 0 && pt_addr <= m_len;
        d_accept  = in_run && pt_wren && ((pt_addr == 0 && pt_wrdata == 0) ||
                                          (body && printable && pt_addr == m_len));
        d_reject  = in_run && body && !printable;
        d_done    = in_run && a4_rdy && !m_prev_rdy;
        exp_abort = in_run && !d_accept && (kill || d_reject);
        exp_en    = (m_phase == P_WAIT) && a4_rdy && !kill;
        exp_rdy   = (m_phase == P_IDLE) || (m_phase == P_FOUND) || (m_phase == P_EXH);
        chk("rdy", 32'(rdy), 32'(exp_rdy));
        chk("key", 32'(key), m_key);
        chk("a4_key", 32'(a4_key), m_key);
        chk("key_valid", 32'(key_valid), 32'(m_kv));
        chk("found", 32'(found), 32'(m_found));
        chk("str_len", 32'(str_len), 32'(m_len));
        chk("keys_tried", 32'(keys_tried), m_tried);
        chk("a4_en", 32'(a4_en), 32'(exp_en));
        chk("a4_abort", 32'(a4_abort), 32'(exp_abort));
        if (rst_n) begin
            m_found    = 0;
            m_prev_rdy = a4_rdy;
            case (m_phase)
                P_IDLE, P_FOUND, P_EXH:
                    if (en) begin m_key = 0; m_tried = 0; m_kv = 0; m_len = 0; m_phase = P_WAIT; end
                P_WAIT:
                    if (kill) begin m_kv = 0; m_phase = P_IDLE; end
                    else if (a4_rdy) m_phase = P_RUN;
                P_RUN: begin
                    if (pt_wren && pt_addr == 0) m_len = pt_wrdata;
                    if (d_accept) begin m_kv = 1; m_found = 1; m_phase = P_FOUND; end
                    else if (kill) begin m_kv = 0; m_phase = P_IDLE; end
                    else if (d_reject || d_done) m_phase = P_STEP;
                end
                default:
                    if (kill) begin m_kv = 0; m_phase = P_IDLE; end
                    else begin
                        m_tried = m_tried + 1;
                        if (m_key + 1 > 32'hFF_FFFF) m_phase = P_EXH;
                        else begin m_key = m_key + 1; m_phase = P_WAIT; end
                    end
            endcase
        end
    endtask

    logic rst_req, en_req, kill_req, en2_req, kill_on_final;
    int   cyc, n_abort, n_found, n_en, en_cyc, ab_cyc, wr_cyc, fd_cyc;
    logic ab_final;
    logic [31:0] en_key_first;

    task automatic cycle();
        @(negedge clk);
        rst_n = rst_req; en = en_req; kill = kill_req; en2 = en2_req; kill2 = 1'b0;
        if (!rst_n) core_reset(); else core_drive();
        if (kill_on_final && pt_wren && c_key == 3 && pt_addr == 8'd3) begin
            kill = 1; wr_cyc = cyc;
        end else if (c_mode == 0 && pt_wren && c_key == 3 && pt_addr == 8'd3) begin
            wr_cyc = cyc;
        end
        #1;
        check_and_step();
        if (kill_on_final && kill) ab_final = a4_abort;
        if (a4_abort) begin n_abort++; if (ab_cyc < 0) ab_cyc = cyc; end
        if (found) begin n_found++; fd_cyc = cyc; end
        if (a4_en) begin
            n_en++;
            if (n_en == 1) en_key_first = 32'(a4_key);
            if (ab_cyc >= 0 && en_cyc < 0) en_cyc = cyc;
        end
        en_seen = a4_en; abort_seen = a4_abort; en_key_cap = 32'(a4_key);
        en2_seen = a4_en2; ab2_seen = a4_abort2;
        if (a4_en2) q2.push_back(32'(a4_key2));
        cyc++;
    endtask

    task automatic clear_counts();
        n_abort = 0; n_found = 0; n_en = 0; en_cyc = -1; ab_cyc = -1; wr_cyc = -1; fd_cyc = -1;
    endtask

    task automatic run_until_done(input int budget, input string name);
        logic done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            if (m_phase == P_IDLE || m_phase == P_FOUND || m_phase == P_EXH) done = 1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic run_until_key(input logic [31:0] k, input int budget, input string name);
        logic hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            cycle();
            if (m_phase == P_RUN && m_key == k) hit = 1;
        end
        chk(name, 32'(hit), 32'd1);
    endtask

    initial begin
        rst_n = 0; rst_req = 0; en_req = 0; kill_req = 0; en2_req = 0; kill_on_final = 0;
        en = 0; kill = 0; en2 = 0; kill2 = 0;
        c_mode = 0; c_seed = 0; abort_delay = 5; cyc = 0; ab_final = 1'b1; en_key_first = 0;
        core_reset(); model_reset(); clear_counts();

        // Reset values on both parameterisations
        cycle(); cycle();
        chk("reset rdy", 32'(rdy), 32'd1);
        chk("reset key", 32'(key), 32'd0);
        chk("reset keys_tried", 32'(keys_tried), 32'd0);
        chk("reset dut2 key=OFFSET", 32'(key2), 32'd1);
        chk("reset dut2 rdy", 32'(rdy2), 32'd1);
        rst_req = 1;
        cycle(); cycle();

        // Key 3 is the only printable candidate; abort hold of 5 cycles on the core
        c_mode = 0; abort_delay = 5; clear_counts();
        en_req = 1; cycle(); en_req = 0;
        run_until_done(400, "search key3 done");
        for (int i = 0; i < 4; i++) cycle();
        chk("key3 key", 32'(key), 32'd3);
        chk("key3 key_valid", 32'(key_valid), 32'd1);
        chk("key3 keys_tried", 32'(keys_tried), 32'd3);
        chk("key3 str_len", 32'(str_len), 32'd3);
        chk("key3 found pulses", 32'(n_found), 32'd1);
        chk("key3 abort pulses", 32'(n_abort), 32'd3);
        chk("key3 found one cycle after addr3 write", 32'(fd_cyc - wr_cyc), 32'd1);
        chk("abort to relaunch gap", 32'(en_cyc - ab_cyc), 32'd6);

        // Empty message on the very first key
        c_mode = 1; abort_delay = -1; clear_counts();
        en_req = 1; cycle(); en_req = 0;
        run_until_done(100, "empty msg done");
        cycle();
        chk("empty key", 32'(key), 32'd0);
        chk("empty str_len", 32'(str_len), 32'd0);
        chk("empty keys_tried", 32'(keys_tried), 32'd0);
        chk("empty key_valid", 32'(key_valid), 32'd1);

        // Kill while running key 9, then restart from OFFSET
        c_mode = 3; clear_counts();
        en_req = 1; cycle(); en_req = 0;
        run_until_key(32'd9, 600, "reach key9");
        n_abort = 0;
        kill_req = 1; cycle(); kill_req = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("kill abort pulses", 32'(n_abort), 32'd1);
        chk("kill rdy", 32'(rdy), 32'd1);
        chk("kill key held", 32'(key), 32'd9);
        chk("kill key_valid", 32'(key_valid), 32'd0);
        n_en = 0;
        en_req = 1; cycle(); en_req = 0;
        for (int i = 0; i < 20 && n_en == 0; i++) cycle();
        chk("restart first key", en_key_first, 32'd0);
        kill_req = 1; cycle(); kill_req = 0;
        run_until_done(20, "restart killed");

        // Kill on the same cycle as the final printable write
        c_mode = 0; clear_counts(); kill_on_final = 1;
        en_req = 1; cycle(); en_req = 0;
        run_until_done(400, "kill+final done");
        kill_on_final = 0;
        cycle();
        chk("kill+final key_valid", 32'(key_valid), 32'd1);
        chk("kill+final key", 32'(key), 32'd3);
        chk("kill+final found", 32'(n_found), 32'd1);
        chk("kill+final no abort", 32'(ab_final), 32'd0);

        // Asynchronous reset in the middle of key 5
        c_mode = 3; clear_counts();
        en_req = 1; cycle(); en_req = 0;
        run_until_key(32'd5, 600, "reach key5");
        cycle();
        #1 rst_n = 0;
        #1;
        chk("async rdy", 32'(rdy), 32'd1);
        chk("async key", 32'(key), 32'd0);
        chk("async key_valid", 32'(key_valid), 32'd0);
        chk("async a4_en", 32'(a4_en), 32'd0);
        chk("async a4_abort", 32'(a4_abort), 32'd0);
        rst_req = 0; core_reset(); model_reset();
        cycle();
        rst_req = 1;
        cycle();

        // Randomised plaintexts, random kills
        c_mode = 2; abort_delay = -1;
        for (int s = 0; s < 8; s++) begin
            c_seed = $urandom;
            en_req = 1; cycle(); en_req = 0;
            begin
                logic done;
                done = 0;
                for (int i = 0; i < 4000 && !done; i++) begin
                    kill_req = ($urandom_range(0, 199) == 0);
                    cycle();
                    if (m_phase == P_IDLE || m_phase == P_FOUND || m_phase == P_EXH) done = 1;
                end
                kill_req = 0;
                chk("random search done", 32'(done), 32'd1);
            end
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) cycle();
        end

        // Four-bit key space, stride 2 from offset 1, nothing printable
        q2.delete();
        en2_req = 1; cycle(); en2_req = 0;
        begin
            logic done;
            done = 0;
            for (int i = 0; i < 500 && !done; i++) begin
                cycle();
                if (rdy2) done = 1;
            end
            chk("exhaust done", 32'(done), 32'd1);
        end
        chk("exhaust tried count", 32'(q2.size()), 32'd8);
        for (int i = 0; i < q2.size() && i < 8; i++) chk("exhaust key seq", q2[i], 32'(1 + 2 * i));
        chk("exhaust key", 32'(key2), 32'd15);
        chk("exhaust keys_tried", 32'(keys_tried2), 32'd8);
        chk("exhaust key_valid", 32'(key_valid2), 32'd0);
        chk("exhaust rdy", 32'(rdy2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
